// File: rtl/mii_rx_pkg.sv
// Shared types and constants for the MII/RMII receive lane packer.
package mii_rx_pkg;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} rx_state_t;

  localparam logic [7:0] SFD      = 8'hD5;
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam int         LEN_W    = 11;

endpackage

// File: rtl/mii_lane_shift.sv
// Lane shift register: SFD search window before the frame, byte assembly after it.
// Lanes enter at the top so the first lane of a byte ends up in bits [IN_W-1:0].
module mii_lane_shift
  import mii_rx_pkg::*;
#(
  parameter int IN_W = 4
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            shift,
  input  logic            count,
  input  logic [IN_W-1:0] lane,
  output logic [7:0]      byte_nxt,
  output logic            sfd_hit,
  output logic            phase_wrap,
  output logic            phase_nz
);

  localparam int K  = 8 / IN_W;
  localparam int PW = (K > 1) ? $clog2(K) : 1;

  logic [7:0]    sr;
  logic [PW-1:0] phase;

  assign byte_nxt   = {lane, sr[7:IN_W]};
  assign sfd_hit    = (byte_nxt == SFD);
  assign phase_wrap = (phase == PW'(K - 1));
  assign phase_nz   = (phase != '0);

  // Phase only advances while assembling payload; it sits at 0 otherwise.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      phase <= '0;
    end else if (clr) begin
      sr    <= '0;
      phase <= '0;
    end else if (shift) begin
      sr    <= byte_nxt;
      phase <= (count && !phase_wrap) ? phase + PW'(1) : '0;
    end
  end

endmodule

// File: rtl/mii_rx_lane_packer.sv
// Receive lane-to-byte packer: finds the SFD at any lane alignment, then emits
// payload bytes with sof/eof framing, byte count and per-frame error pulses.
module mii_rx_lane_packer
  import mii_rx_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int MIN_PRE   = 10,
  parameter int MAX_PRE   = 40,
  parameter int MAX_BYTES = 1522
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  datain,
  input  logic             ena,
  output logic [7:0]       dataout,
  output logic             ren,
  output logic             sof,
  output logic             eof,
  output logic [LEN_W-1:0] frame_len,
  output logic             err_pre,
  output logic             err_align,
  output logic             err_long
);

  localparam int              PCW = $clog2(MAX_PRE + 1);
  localparam logic [IN_W-1:0] PL  = PRE_BYTE[IN_W-1:0];

  rx_state_t        state, nxt;
  logic [IN_W-1:0]  d_r;
  logic             v_r;
  logic [PCW-1:0]   pre_cnt, pre_inc;
  logic             pre_ok, pre_max;
  logic [7:0]       hold;
  logic             hold_v;
  logic [LEN_W-1:0] byte_cnt;
  logic [7:0]       byte_nxt;
  logic             sfd_hit, phase_wrap, phase_nz;
  logic             load, emit_run, emit_end, long_hit;
  logic             ren_n, sof_n, eof_n, epre_n, ealign_n;

  assign pre_inc = pre_cnt + PCW'(1);
  assign pre_ok  = (pre_cnt >= PCW'(MIN_PRE));
  assign pre_max = (pre_inc == PCW'(MAX_PRE));

  // Any v_r=0 cycle leads to IDLE, so that is also when the window is cleared.
  mii_lane_shift #(.IN_W(IN_W)) u_shift (
    .clock      (clock),
    .rst_n      (rst_n),
    .clr        (!v_r),
    .shift      (v_r && (state != DROP)),
    .count      (state == DATA),
    .lane       (d_r),
    .byte_nxt   (byte_nxt),
    .sfd_hit    (sfd_hit),
    .phase_wrap (phase_wrap),
    .phase_nz   (phase_nz)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (v_r) nxt = PRE;
      PRE: begin
        if (!v_r)                      nxt = IDLE;
        else if (sfd_hit)              nxt = pre_ok ? DATA : DROP;
        else if (d_r != PL || pre_max) nxt = DROP;
      end
      DATA: begin
        if (!v_r)          nxt = IDLE;
        else if (long_hit) nxt = DROP;
      end
      DROP: if (!v_r) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // A completed byte waits in hold until the next one completes or the frame
  // ends, so the last byte can be tagged with eof.
  always_comb begin
    load     = (state == DATA) && v_r && phase_wrap;
    emit_run = load && hold_v;
    emit_end = (state == DATA) && !v_r && hold_v;
    long_hit = emit_run && (byte_cnt == LEN_W'(MAX_BYTES - 1));
    ren_n    = emit_run || emit_end;
    sof_n    = ren_n && (byte_cnt == '0);
    eof_n    = emit_end || long_hit;
    epre_n   = (state == PRE) && (nxt == DROP);
    ealign_n = (state == DATA) && !v_r && phase_nz;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      d_r       <= '0;
      v_r       <= 1'b0;
      pre_cnt   <= '0;
      hold      <= '0;
      hold_v    <= 1'b0;
      byte_cnt  <= '0;
      dataout   <= '0;
      frame_len <= '0;
      ren       <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      err_pre   <= 1'b0;
      err_align <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      d_r       <= datain;
      v_r       <= ena;
      ren       <= ren_n;
      sof       <= sof_n;
      eof       <= eof_n;
      err_pre   <= epre_n;
      err_align <= ealign_n;
      err_long  <= long_hit;

      if (state == IDLE)
        pre_cnt <= (v_r && d_r == PL) ? PCW'(1) : '0;
      else if (state == PRE && v_r && d_r == PL)
        pre_cnt <= pre_inc;

      if (load) hold <= byte_nxt;
      if (nxt != DATA) hold_v <= 1'b0;
      else if (load)   hold_v <= 1'b1;

      if (state != DATA) byte_cnt <= '0;
      else if (ren_n)    byte_cnt <= byte_cnt + LEN_W'(1);

      if (ren_n) dataout <= hold;

      if (long_hit)      frame_len <= LEN_W'(MAX_BYTES);
      else if (emit_end) frame_len <= byte_cnt + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_mii_rx_lane_packer.sv
// Bench for mii_rx_lane_packer: MII, RMII and short-MAX_BYTES instances driven
// one at a time from a vector table, hand sequences and random frames.
module tb_mii_rx_lane_packer;

  localparam int NI    = 3;
  localparam int MIN_P = 10;
  localparam int MAX_P = 40;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  din    [NI];
  logic        ena    [NI];
  logic [7:0]  dout   [NI];
  logic        ren    [NI];
  logic        sof    [NI];
  logic        eof    [NI];
  logic        epre   [NI];
  logic        ealign [NI];
  logic        elong  [NI];
  logic [10:0] flen   [NI];

  always #5 clock = ~clock;

  mii_rx_lane_packer #(.IN_W(4)) u_mii (
    .clock(clock), .rst_n(rst_n), .datain(din[0]), .ena(ena[0]),
    .dataout(dout[0]), .ren(ren[0]), .sof(sof[0]), .eof(eof[0]), .frame_len(flen[0]),
    .err_pre(epre[0]), .err_align(ealign[0]), .err_long(elong[0]));

  mii_rx_lane_packer #(.IN_W(2)) u_rmii (
    .clock(clock), .rst_n(rst_n), .datain(din[1][1:0]), .ena(ena[1]),
    .dataout(dout[1]), .ren(ren[1]), .sof(sof[1]), .eof(eof[1]), .frame_len(flen[1]),
    .err_pre(epre[1]), .err_align(ealign[1]), .err_long(elong[1]));

  mii_rx_lane_packer #(.IN_W(4), .MAX_BYTES(8)) u_short (
    .clock(clock), .rst_n(rst_n), .datain(din[2]), .ena(ena[2]),
    .dataout(dout[2]), .ren(ren[2]), .sof(sof[2]), .eof(eof[2]), .frame_len(flen[2]),
    .err_pre(epre[2]), .err_align(ealign[2]), .err_long(elong[2]));

  typedef struct { logic [7:0] d; logic s; logic e; } ev_t;
  ev_t evq[$];
  int  cyc = 0;
  int  f_pre[NI], f_align[NI], f_long[NI], f_eof[NI];
  int  eof_cyc[NI], align_cyc[NI], long_cyc[NI];
  int  n_chk = 0, n_pass = 0;
  int  c_drop;
  int  last_len[NI];
  logic [7:0] pay[$];

  // Only one instance is active at a time, so a single byte log suffices.
  initial forever begin
    @(negedge clock);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (ren[i])    evq.push_back('{dout[i], sof[i], eof[i]});
      if (eof[i])    begin f_eof[i]++;   eof_cyc[i]   = cyc; end
      if (epre[i])   f_pre[i]++;
      if (ealign[i]) begin f_align[i]++; align_cyc[i] = cyc; end
      if (elong[i])  begin f_long[i]++;  long_cyc[i]  = cyc; end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int iw_of(input int i);
    return (i == 1) ? 2 : 4;
  endfunction

  function automatic int maxb_of(input int i);
    return (i == 2) ? 8 : 1522;
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic put(input int i, input logic [3:0] v, input logic e);
    tick();
    din[i] = v;
    ena[i] = e;
  endtask

  task automatic clr_obs();
    evq.delete();
    for (int i = 0; i < NI; i++) begin
      f_pre[i] = 0; f_align[i] = 0; f_long[i] = 0; f_eof[i] = 0;
      eof_cyc[i] = -1; align_cyc[i] = -1; long_cyc[i] = -1;
    end
  endtask

  // npre preamble lanes, SFD final lane, pay[] bytes low lane first, extra lanes, ena low.
  task automatic send(input int i, input int npre, input logic [3:0] last, input int extra);
    int         iw  = iw_of(i);
    logic [3:0] pl  = (iw == 4) ? 4'h5 : 4'h1;
    logic [3:0] msk = (iw == 4) ? 4'hF : 4'h3;
    logic [7:0] sh;
    clr_obs();
    for (int n = 0; n < npre; n++) put(i, pl, 1'b1);
    put(i, last, 1'b1);
    foreach (pay[k])
      for (int l = 0; l < 8 / iw; l++) begin
        sh = pay[k] >> (l * iw);
        put(i, sh[3:0] & msk, 1'b1);
      end
    for (int x = 0; x < extra; x++) put(i, 4'($urandom) & msk, 1'b1);
    put(i, 4'h0, 1'b0);
    c_drop = cyc;
    repeat (5) tick();
  endtask

  // Frame outcome from the rules: preamble length window, SFD lane, byte limit.
  task automatic model(input int i, input int npre, input logic [3:0] last, input int nb,
                       input int extra, output int er, output int el,
                       output bit ep, output bit ea, output bit elg);
    int         k   = 8 / iw_of(i);
    logic [3:0] top = (iw_of(i) == 4) ? 4'hD : 4'h3;
    int         full;
    er = 0; ea = 0; elg = 0; el = last_len[i];
    ep = (npre < MIN_P) || (npre >= MAX_P) || (last != top);
    if (!ep) begin
      full = nb + extra / k;
      if (full > maxb_of(i)) begin er = maxb_of(i); elg = 1; end
      else begin er = full; ea = (extra % k) != 0; end
      if (er > 0) el = er;
    end
    last_len[i] = el;
  endtask

  task automatic check_frame(input string nm, input int i, input int er, input int el,
                             input bit ep, input bit ea, input bit elg);
    int n = (evq.size() < er) ? evq.size() : er;
    chk({nm, " ren count"}, evq.size(), er);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s byte%0d", nm, k), {evq[k].d, evq[k].s, evq[k].e},
          {pay[k], k == 0, k == er - 1});
    chk({nm, " eof count"}, f_eof[i], (er > 0) ? 1 : 0);
    chk({nm, " err_pre"}, f_pre[i], ep);
    chk({nm, " err_align"}, f_align[i], ea);
    chk({nm, " err_long"}, f_long[i], elg);
    chk({nm, " frame_len"}, flen[i], el);
    if (er > 0 && !elg) chk({nm, " eof latency"}, eof_cyc[i] - c_drop, 3);
    if (ea) chk({nm, " align latency"}, align_cyc[i] - c_drop, 3);
    if (elg) chk({nm, " long on eof cycle"}, long_cyc[i], eof_cyc[i]);
  endtask

  typedef struct {
    int inst; int npre; logic [3:0] last; int nb; logic [7:0] b0; logic [7:0] step; int extra;
    int er; int el; bit ep; bit ea; bit elg;
  } vec_t;
  vec_t tbl[14];

  initial begin
    // inst npre last nb b0 step extra | ren len pre align long
    tbl[0]  = '{0, 15, 4'hD, 64, 8'h00, 8'h01, 0, 64, 64, 0, 0, 0};
    tbl[1]  = '{1, 31, 4'h3,  2, 8'hA5, 8'h97, 0,  2,  2, 0, 0, 0};
    tbl[2]  = '{0,  4, 4'hD,  3, 8'h10, 8'h01, 0,  0, 64, 1, 0, 0};
    tbl[3]  = '{0, 12, 4'hD,  3, 8'h20, 8'h11, 0,  3,  3, 0, 0, 0};
    tbl[4]  = '{0, 10, 4'hD,  5, 8'h30, 8'h05, 1,  5,  5, 0, 1, 0};
    tbl[5]  = '{2, 12, 4'hD, 12, 8'h40, 8'h01, 0,  8,  8, 0, 0, 1};
    tbl[6]  = '{0,  9, 4'hD,  2, 8'h00, 8'h01, 0,  0,  5, 1, 0, 0};
    tbl[7]  = '{0, 40, 4'hD,  2, 8'h00, 8'h01, 0,  0,  5, 1, 0, 0};
    tbl[8]  = '{0, 39, 4'hD,  1, 8'h7E, 8'h00, 0,  1,  1, 0, 0, 0};
    tbl[9]  = '{0, 10, 4'hD,  0, 8'h00, 8'h00, 1,  0,  1, 0, 1, 0};
    tbl[10] = '{0, 11, 4'hA,  2, 8'h00, 8'h01, 0,  0,  1, 1, 0, 0};
    tbl[11] = '{2, 12, 4'hD,  8, 8'hC0, 8'h03, 0,  8,  8, 0, 0, 0};
    tbl[12] = '{1, 10, 4'h3,  3, 8'h5A, 8'h21, 3,  3,  3, 0, 1, 0};
    tbl[13] = '{1, 31, 4'h2,  2, 8'h00, 8'h01, 0,  0,  3, 1, 0, 0};

    for (int i = 0; i < NI; i++) begin
      din[i] = '0; ena[i] = 1'b0; last_len[i] = 0;
    end
    clr_obs();

    repeat (3) tick();
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset outputs inst%0d", i),
          {dout[i], ren[i], sof[i], eof[i], epre[i], ealign[i], elong[i], flen[i]}, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int r = 0; r < 14; r++) begin
      pay.delete();
      for (int k = 0; k < tbl[r].nb; k++) pay.push_back(8'(tbl[r].b0 + k * tbl[r].step));
      send(tbl[r].inst, tbl[r].npre, tbl[r].last, tbl[r].extra);
      check_frame($sformatf("row%0d", r), tbl[r].inst, tbl[r].er, tbl[r].el,
                  tbl[r].ep, tbl[r].ea, tbl[r].elg);
      last_len[tbl[r].inst] = tbl[r].el;
    end

    // Reset pulse in the middle of a payload.
    clr_obs();
    for (int n = 0; n < 15; n++) put(0, 4'h5, 1'b1);
    put(0, 4'hD, 1'b1);
    for (int n = 0; n < 8; n++) put(0, 4'h3, 1'b1);
    tick();
    rst_n = 1'b0; ena[0] = 1'b0; din[0] = '0;
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("async reset inst%0d", i),
          {dout[i], ren[i], sof[i], eof[i], epre[i], ealign[i], elong[i], flen[i]}, 0);
    clr_obs();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("reset lost frame bytes", evq.size(), 0);
    chk("reset lost frame eof", f_eof[0], 0);
    for (int i = 0; i < NI; i++) last_len[i] = 0;
    pay.delete();
    for (int k = 0; k < 4; k++) pay.push_back(8'(8'hE1 + k));
    send(0, 15, 4'hD, 0);
    check_frame("after reset", 0, 4, 4, 0, 0, 0);
    last_len[0] = 4;

    for (int r = 0; r < 24; r++) begin
      int i, iw, npre, nb, extra, er, el;
      bit ep, ea, elg;
      logic [3:0] last, pl, top, msk;
      i    = $urandom_range(0, 2);
      iw   = iw_of(i);
      pl   = (iw == 4) ? 4'h5 : 4'h1;
      top  = (iw == 4) ? 4'hD : 4'h3;
      msk  = (iw == 4) ? 4'hF : 4'h3;
      npre = $urandom_range(8, 42);
      last = top;
      if ($urandom_range(0, 5) == 0)
        do last = 4'($urandom) & msk; while (last == pl || last == top);
      nb    = $urandom_range(0, 12);
      extra = $urandom_range(0, 8 / iw - 1);
      pay.delete();
      repeat (nb) pay.push_back(8'($urandom));
      model(i, npre, last, nb, extra, er, el, ep, ea, elg);
      send(i, npre, last, extra);
      check_frame($sformatf("rand%0d inst%0d", r, i), i, er, el, ep, ea, elg);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mii_rx_lane_packer.md
# mii_rx_lane_packer

Parametrised receive-side lane-to-byte packer for the Ethernet PHY path. It accepts IN_W-bit lanes, IN_W=4 for MII or IN_W=2 for RMII, under a data-valid strobe and locates the SFD at any lane alignment. It then emits frame payload as 8-bit bytes with start/end markers, byte count and per-frame error pulses. It sits between the PHY pins and the MAC frame checker, and adds SFD alignment, length limits and end-of-frame framing over the plain nibble-to-byte converter.

## Interface
- IN_W, 4 — lane width in bits; legal values 2, 4; K = 8/IN_W lanes per byte
- MIN_PRE, 10 — minimum preamble lanes before the SFD's final lane
- MAX_PRE, 40 — maximum preamble lanes; the limit is reached when this lane count is hit
- MAX_BYTES, 1522 — maximum payload bytes per frame
- clock  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- datain  in  IN_W  receive lane; first lane of a byte lands in bits [IN_W-1:0]
- ena  in  1  lane-valid strobe (RX_DV)
- dataout  out  8  payload byte, valid while ren=1
- ren  out  1  one-cycle byte strobe
- sof  out  1  with ren: first payload byte of frame
- eof  out  1  with ren: last payload byte of frame
- frame_len  out  11  payload byte count, updated on the eof cycle, held otherwise
- err_pre  out  1  one-cycle pulse: preamble violation
- err_align  out  1  one-cycle pulse: frame ended on a partial byte
- err_long  out  1  one-cycle pulse: MAX_BYTES exceeded

## Operation
- Input stage: datain and ena registered once (d_r, v_r); all decisions use d_r/v_r.
- Window: 8-bit shift register win <= {d_r, win[7:IN_W]} on every v_r=1 cycle; SFD detected when win == 8'hD5 after the shift.
- Preamble lane value PL = 8'h55[IN_W-1:0]; pre_cnt counts consecutive PL lanes.
- States:
  - IDLE: win and pre_cnt are cleared. When v_r=1, go to PRE with that lane shifted in.
  - PRE, SFD detected with pre_cnt ≥ MIN_PRE: go to DATA, phase=0, byte_cnt=0.
  - PRE, SFD detected with pre_cnt < MIN_PRE: err_pre, go to DROP.
  - PRE, any lane other than PL that does not complete the SFD: err_pre, go to DROP.
  - PRE, pre_cnt reaches MAX_PRE: err_pre, go to DROP.
  - PRE, v_r=0: go to IDLE silently.
  - DATA: lanes are packed into an assembly register; phase increments mod K. At phase K-1 the completed byte moves to a hold register (hold_v=1), and any previous hold byte is emitted (ren=1, sof=1 if it is byte 0).
  - DATA, v_r=0: if hold_v=1, emit hold with eof=1 and latch frame_len. If phase≠0, also pulse err_align; the partial byte is discarded. Go to IDLE.
  - DATA, zero complete bytes: no ren, no eof; err_align pulses if phase≠0.
  - DATA, emitting byte number MAX_BYTES: that byte carries eof=1, err_long pulses, frame_len=MAX_BYTES, go to DROP.
  - DROP: all lanes ignored; v_r=0 → IDLE.
- Single-byte frame: ren with sof=1 and eof=1 in the same cycle.
- Byte counter is 11 bits; MAX_BYTES must be ≤ 2047.
- Reset mid-frame: immediate return to IDLE. Next frame requires fresh preamble; the lost frame produces no eof.

## Timing
- Reset values:
  - dataout=0, ren=0, sof=0, eof=0, frame_len=0, all err_*=0
  - state=IDLE, hold_v=0
- All outputs are registered; ren, sof, eof and err_* are single-cycle.
- Byte latency: byte N is emitted one cycle after its last lane leaves the input stage, when byte N+1 completes (K cycles later in streaming).
- End latency: eof byte is emitted 2 cycles after the first ena=0 sample at the pin.
- Error pulses are asserted on the same cycle as the transition they cause.
- ena gaps inside DATA are not tolerated; any v_r=0 ends the frame.

## Structure
- Package mii_rx_pkg: state enum {IDLE, PRE, DATA, DROP}, SFD=8'hD5, PRE_BYTE=8'h55, LEN_W=11.
- Sub-module mii_lane_shift: parametrised IN_W shift/assembly register with phase counter and window compare output. It is instantiated once; the FSM, hold stage and counters stay in the top.

## Test plan
- MII, 15 lanes 0x5 + 0xD, 64 bytes 0x00..0x3F, ena low → 64 ren, sof on 0x00, eof on 0x3F, frame_len=64, no errors.
- RMII (IN_W=2), 31 lanes 2'b01 + 2'b11, bytes 0xA5,0x3C → dataout 0xA5 (sof) then 0x3C (eof), frame_len=2.
- MII, 4 preamble nibbles + 0xD → err_pre, no ren until ena low; next valid frame is received normally.
- MII, valid preamble/SFD, 5 bytes + 1 extra nibble → 5 ren, eof on byte 5, err_align pulse same cycle, frame_len=5.
- MAX_BYTES=8, 12-byte payload → 8 ren, eof and err_long on byte 8, remaining lanes dropped.
- rst_n low for 1 cycle mid-payload → all outputs 0, no eof; following frame received with frame_len correct.
